// File: rtl/cam_row_writer.sv
// cam_row_writer: write-side controller for the CAM row array.
// Accepts write/invalidate requests, picks a row (explicit or lowest free),
// and sequences setup / write-enable / hold around a one-hot row enable.
// Owns the per-row valid bitmap used to gate the match lines.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request or a flush
// SETUP | row_wdata driven with the captured word, no enable yet
// WRITE | one-hot enable on the selected row (none for invalidate)
// HOLD  | enable dropped, data still held, response pulse on the outputs
module cam_row_writer #(
  parameter int ROW_NUM     = 68,
  parameter int ENTRY_WIDTH = 7,
  parameter int WORD_SIZE   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic                   req_addr_valid,
  input  logic [ENTRY_WIDTH-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]   req_data,
  output logic [WORD_SIZE-1:0]   row_wdata,
  output logic [ROW_NUM-1:0]     row_write_en,
  output logic [ROW_NUM-1:0]     valid_array,
  output logic                   full,
  output logic                   resp_valid,
  output logic [ENTRY_WIDTH-1:0] resp_addr,
  output logic                   resp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                 state;
  logic                   op_q;
  logic [ENTRY_WIDTH-1:0] row_q;

  logic                   transfer;
  logic                   free_found;
  logic [ENTRY_WIDTH-1:0] free_idx;
  logic [31:0]            addr_ext;
  logic                   sel_err;
  logic [ENTRY_WIDTH-1:0] sel_row;

  assign req_ready = (state == IDLE) & ~flush;
  assign transfer  = req_valid & req_ready;
  assign full      = &valid_array;
  // Widen before comparing so ROW_NUM == 2**ENTRY_WIDTH still works.
  assign addr_ext  = 32'(req_addr);

  // Lowest-index row whose valid bit is clear; scanning downward lets the
  // last hit (the lowest index) win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ROW_NUM - 1; i >= 0; i--) begin
      if (!valid_array[i]) begin
        free_found = 1'b1;
        free_idx   = ENTRY_WIDTH'(i);
      end
    end
  end

  // Row selection and error decision for the request being offered now.
  always_comb begin
    sel_row = '0;
    sel_err = 1'b0;
    if (req_addr_valid) begin
      sel_row = req_addr;
      sel_err = (addr_ext >= 32'(ROW_NUM));
    end else if (req_op) begin
      sel_err = 1'b1;
    end else begin
      sel_row = free_idx;
      sel_err = ~free_found;
    end
  end

  // Sequencer: state, captured request, registered row-bus and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= 1'b0;
      row_q        <= '0;
      row_wdata    <= '0;
      row_write_en <= '0;
      valid_array  <= '0;
      resp_valid   <= 1'b0;
      resp_addr    <= '0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid_array <= '0;
          end else if (transfer) begin
            if (sel_err) begin
              // Rejected requests skip the row bus entirely.
              state      <= HOLD;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_addr  <= '0;
            end else begin
              state     <= SETUP;
              op_q      <= req_op;
              row_q     <= sel_row;
              row_wdata <= req_data;
            end
          end
        end
        SETUP: begin
          if (!op_q) begin
            row_write_en <= {{(ROW_NUM-1){1'b0}}, 1'b1} << row_q;
          end
          state <= WRITE;
        end
        WRITE: begin
          row_write_en       <= '0;
          valid_array[row_q] <= ~op_q;
          state              <= HOLD;
          resp_valid         <= 1'b1;
          resp_err           <= 1'b0;
          resp_addr          <= row_q;
        end
        HOLD: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
